// File: rtl/fm_tx_pkg.sv
// Register map, ctrl bit positions and FSM states shared by the FM transmit controller.
package fm_tx_pkg;

   localparam logic [2:0] ADDR_ACC_LO  = 3'd0;
   localparam logic [2:0] ADDR_ACC_MID = 3'd1;
   localparam logic [2:0] ADDR_ACC_HI  = 3'd2;
   localparam logic [2:0] ADDR_MOD_CFG = 3'd3;
   localparam logic [2:0] ADDR_DIV_LO  = 3'd4;
   localparam logic [2:0] ADDR_DIV_HI  = 3'd5;
   localparam logic [2:0] ADDR_CTRL    = 3'd6;

   localparam int CTRL_TX_EN   = 0;
   localparam int CTRL_COMMIT  = 1;
   localparam int CTRL_CLR_UR  = 2;
   localparam int CFG_MSEL     = 7;
   localparam int CFG_FACT_LSB = 4;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2,
      ST_MUTE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/fm_sample_divider.sv
// Sample-rate divider: down-counter over div, registered one-cycle tick every div+1 cycles.
module fm_sample_divider #(
   parameter int DIVW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DIVW-1:0] div,
   output logic            tick
);

   logic [DIVW-1:0] count_q, count_d;
   logic            tick_q, tick_d;

   always_comb begin
      tick_d  = (count_q == '0);
      count_d = tick_d ? div : count_q - DIVW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/fm_tx_controller.sv
// FM modulator sequencer: shadow/active config registers, sample tick, one-entry audio buffer.
// Optional soft mute ramp-down is enabled by defining SOFT_MUTE_EN.
module fm_tx_controller
   import fm_tx_pkg::*;
#(
   parameter int A    = 8,
   parameter int K    = 4,
   parameter int L    = 2,
   parameter int N    = 18,
   parameter int DIVW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [2:0]      wr_addr,
   input  logic [7:0]      wr_data,
   input  logic [A-1:0]    audio_in,
   input  logic            audio_valid,
   output logic            audio_ready,
   output logic [A-1:0]    audio,
   output logic [N-1:0]    acc_inc,
   output logic [K-1:0]    df_inc_coef,
   output logic [L-1:0]    df_inc_fact,
   output logic            multiply_sel,
   output logic            sample_tick,
   output logic            tx_on,
   output logic            underrun
);

`ifdef SOFT_MUTE_EN
   localparam tx_state_e LEAVE_ST = ST_MUTE;
`else
   localparam tx_state_e LEAVE_ST = ST_OFF;
`endif

   tx_state_e       state_q, state_d;
   logic [N-1:0]    sh_acc_q, sh_acc_d, act_acc_q, act_acc_d;
   logic [K-1:0]    sh_coef_q, sh_coef_d, act_coef_q, act_coef_d;
   logic [L-1:0]    sh_fact_q, sh_fact_d, act_fact_q, act_fact_d;
   logic            sh_msel_q, sh_msel_d, act_msel_q, act_msel_d;
   logic [DIVW-1:0] sh_div_q, sh_div_d, act_div_q, act_div_d;
   logic [A-1:0]    buf_q, buf_d, audio_q, audio_d;
   logic            buf_full_q, buf_full_d, underrun_q, underrun_d;
   logic            tick, ctrl_wr, tx_en_w, tx_off_w, commit_w, clr_w, copy, drain;

   fm_sample_divider #(.DIVW(DIVW)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (act_div_q),
      .tick  (tick)
   );

   always_comb begin
      ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
      tx_en_w  = ctrl_wr &&  wr_data[CTRL_TX_EN];
      tx_off_w = ctrl_wr && !wr_data[CTRL_TX_EN];
      commit_w = ctrl_wr &&  wr_data[CTRL_COMMIT];
      clr_w    = ctrl_wr &&  wr_data[CTRL_CLR_UR];

      sh_acc_d  = sh_acc_q;
      sh_coef_d = sh_coef_q;
      sh_fact_d = sh_fact_q;
      sh_msel_d = sh_msel_q;
      sh_div_d  = sh_div_q;
      if (wr_en) begin
         case (wr_addr)
            ADDR_ACC_LO:  sh_acc_d[7:0]    = wr_data;
            ADDR_ACC_MID: sh_acc_d[15:8]   = wr_data;
            ADDR_ACC_HI:  sh_acc_d[N-1:16] = wr_data[N-17:0];
            ADDR_MOD_CFG: begin
               sh_msel_d = wr_data[CFG_MSEL];
               sh_fact_d = wr_data[CFG_FACT_LSB +: L];
               sh_coef_d = wr_data[K-1:0];
            end
            ADDR_DIV_LO:  sh_div_d[7:0]      = wr_data;
            ADDR_DIV_HI:  sh_div_d[DIVW-1:8] = wr_data[DIVW-9:0];
            default: ;
         endcase
      end

      state_d = state_q;
      audio_d = audio_q;
      copy    = 1'b0;
      drain   = 1'b0;
      case (state_q)
         ST_OFF: begin
            copy = commit_w;
            if (tx_en_w) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (tx_off_w) state_d = LEAVE_ST;
            else begin
               drain = tick;
               if (commit_w) state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            // further commits are absorbed; the tick applies whatever shadow holds now
            if (tx_off_w) state_d = LEAVE_ST;
            else begin
               drain = tick;
               if (tick) begin
                  copy    = 1'b1;
                  state_d = ST_RUN;
               end
            end
         end
`ifdef SOFT_MUTE_EN
         ST_MUTE: begin
            if (tx_en_w) state_d = ST_RUN;
            else if (tick) begin
               if (audio_q == '0 || audio_q == '1) state_d = ST_OFF;
               else audio_d = $signed(audio_q) >>> 1;
            end
         end
`endif
         default: state_d = ST_OFF;
      endcase

      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      underrun_d = clr_w ? 1'b0 : underrun_q;
      if (drain) begin
         if (buf_full_q) begin
            audio_d    = buf_q;
            buf_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end
      if (audio_valid && !buf_full_q) begin
         buf_d      = audio_in;
         buf_full_d = 1'b1;
      end
      if (state_d == ST_OFF) audio_d = '0;

      act_acc_d  = copy ? sh_acc_q  : act_acc_q;
      act_coef_d = copy ? sh_coef_q : act_coef_q;
      act_fact_d = copy ? sh_fact_q : act_fact_q;
      act_msel_d = copy ? sh_msel_q : act_msel_q;
      act_div_d  = copy ? sh_div_q  : act_div_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_OFF;
         sh_acc_q   <= '0;
         sh_coef_q  <= '0;
         sh_fact_q  <= '0;
         sh_msel_q  <= 1'b0;
         sh_div_q   <= '0;
         act_acc_q  <= '0;
         act_coef_q <= '0;
         act_fact_q <= '0;
         act_msel_q <= 1'b0;
         act_div_q  <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         audio_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_acc_q   <= sh_acc_d;
         sh_coef_q  <= sh_coef_d;
         sh_fact_q  <= sh_fact_d;
         sh_msel_q  <= sh_msel_d;
         sh_div_q   <= sh_div_d;
         act_acc_q  <= act_acc_d;
         act_coef_q <= act_coef_d;
         act_fact_q <= act_fact_d;
         act_msel_q <= act_msel_d;
         act_div_q  <= act_div_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         audio_q    <= audio_d;
         underrun_q <= underrun_d;
      end
   end

   assign audio_ready  = ~buf_full_q;
   assign audio        = audio_q;
   assign acc_inc      = (state_q == ST_OFF) ? '0 : act_acc_q;
   assign df_inc_coef  = act_coef_q;
   assign df_inc_fact  = act_fact_q;
   assign multiply_sel = act_msel_q;
   assign sample_tick  = tick;
   assign tx_on        = (state_q != ST_OFF);
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_fm_tx_controller.sv
// Bench for fm_tx_controller: register table, directed tick/audio/mute sequences, random run vs model.
module tb_fm_tx_controller;

   localparam int M_OFF = 0, M_RUN = 1, M_PEND = 2, M_MUTE = 3;

   logic        clk, rst_n, wr_en, audio_valid;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data, audio_in, audio;
   logic [17:0] acc_inc;
   logic [3:0]  df_inc_coef;
   logic [1:0]  df_inc_fact;
   logic        audio_ready, multiply_sel, sample_tick, tx_on, underrun;

   int checks = 0;
   int errors = 0;

   fm_tx_controller dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .audio_in(audio_in), .audio_valid(audio_valid), .audio_ready(audio_ready),
      .audio(audio), .acc_inc(acc_inc), .df_inc_coef(df_inc_coef), .df_inc_fact(df_inc_fact),
      .multiply_sel(multiply_sel), .sample_tick(sample_tick), .tx_on(tx_on), .underrun(underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model: transaction-level view of the register file, tick schedule and audio buffer
   int               m_mode, m_cyc, m_next_zero;
   logic [17:0]      m_sh_acc, m_act_acc;
   logic [3:0]       m_sh_coef, m_act_coef;
   logic [1:0]       m_sh_fact, m_act_fact;
   logic             m_sh_msel, m_act_msel, m_full, m_ur, m_tick;
   logic [11:0]      m_sh_div, m_act_div;
   logic [7:0]       m_buf;
   logic signed [7:0] m_audio;

   task automatic model_reset();
      m_mode = M_OFF; m_cyc = 0; m_next_zero = 0;
      m_sh_acc = '0; m_act_acc = '0; m_sh_coef = '0; m_act_coef = '0;
      m_sh_fact = '0; m_act_fact = '0; m_sh_msel = 0; m_act_msel = 0;
      m_sh_div = '0; m_act_div = '0; m_buf = '0; m_full = 0; m_ur = 0; m_tick = 0; m_audio = '0;
   endtask

   task automatic model_step();
      bit ctrl, ten, off, com, clr, tick, full0, drain, copy;
      int nxt;
      tick  = m_tick;
      // the tick appears the cycle after the counter hits zero; the next zero is div+1 later
      m_tick = (m_cyc == m_next_zero);
      if (m_tick) m_next_zero = m_cyc + 1 + int'(m_act_div);
      m_cyc++;
      ctrl = wr_en && wr_addr == 3'd6;
      ten  = ctrl && wr_data[0];
      off  = ctrl && !wr_data[0];
      com  = ctrl && wr_data[1];
      clr  = ctrl && wr_data[2];
      full0 = m_full;
      drain = 0; copy = 0; nxt = m_mode;
      if (m_mode == M_OFF) begin
         copy = com;
         if (ten) nxt = M_RUN;
      end else if (m_mode == M_MUTE) begin
         if (ten) nxt = M_RUN;
         else if (tick) begin
            if (m_audio == 0 || m_audio == -1) nxt = M_OFF;
            else m_audio = m_audio >>> 1;
         end
      end else if (off) begin
`ifdef SOFT_MUTE_EN
         nxt = M_MUTE;
`else
         nxt = M_OFF;
`endif
      end else begin
         drain = tick;
         if (m_mode == M_RUN && com) nxt = M_PEND;
         if (m_mode == M_PEND && tick) begin copy = 1; nxt = M_RUN; end
      end
      if (clr) m_ur = 0;
      if (drain && full0) begin m_audio = m_buf; m_full = 0; end
      if (drain && !full0) m_ur = 1;
      if (audio_valid && !full0) begin m_buf = audio_in; m_full = 1; end
      if (nxt == M_OFF) m_audio = 0;
      if (copy) begin
         m_act_acc = m_sh_acc; m_act_coef = m_sh_coef; m_act_fact = m_sh_fact;
         m_act_msel = m_sh_msel; m_act_div = m_sh_div;
      end
      if (wr_en) begin
         case (wr_addr)
            3'd0: m_sh_acc[7:0] = wr_data;
            3'd1: m_sh_acc[15:8] = wr_data;
            3'd2: m_sh_acc[17:16] = wr_data[1:0];
            3'd3: begin m_sh_msel = wr_data[7]; m_sh_fact = wr_data[5:4]; m_sh_coef = wr_data[3:0]; end
            3'd4: m_sh_div[7:0] = wr_data;
            3'd5: m_sh_div[11:8] = wr_data[3:0];
            default: ;
         endcase
      end
      m_mode = nxt;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cyc_step();
      logic [36:0] got, exp;
      @(posedge clk);
      model_step();
      #1;
      got = {audio, acc_inc, df_inc_coef, df_inc_fact, multiply_sel, sample_tick, tx_on, underrun, audio_ready};
      exp = {m_audio, (m_mode == M_OFF) ? 18'h0 : m_act_acc, m_act_coef, m_act_fact, m_act_msel,
             m_tick, m_mode != M_OFF, m_ur, !m_full};
      chk($sformatf("model cyc %0d", m_cyc), 64'(got), 64'(exp));
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      cyc_step();
      wr_en = 0;
   endtask

   task automatic push(input logic [7:0] d);
      audio_valid = 1; audio_in = d;
      cyc_step();
      audio_valid = 0;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 64; i++) begin
         if (sample_tick) return;
         cyc_step();
      end
      checks++; errors++;
      $display("FAIL tick_timeout: no sample_tick within 64 cycles");
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic [7:0]  data;
      logic [17:0] exp_acc;
      logic        exp_tx_on;
   } vec_t;

   vec_t tbl [8];
   logic [7:0] src_q[$];
   logic [7:0] got_q[$];

   initial begin
      int n;
      bit hs, tk, stalled;
      rst_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0; audio_in = '0; audio_valid = 0;
      #12;
      chk("reset_acc", 64'(acc_inc), 0);
      chk("reset_ready", 64'(audio_ready), 1);
      chk("reset_tx_on", 64'(tx_on), 0);
      chk("reset_tick", 64'(sample_tick), 0);
      rst_n = 1;
      model_reset();

      // OFF-state configuration and commit
      tbl[0] = '{3'd0, 8'hD7, 18'h0, 1'b0};
      tbl[1] = '{3'd1, 8'hA3, 18'h0, 1'b0};
      tbl[2] = '{3'd2, 8'h00, 18'h0, 1'b0};
      tbl[3] = '{3'd3, 8'h25, 18'h0, 1'b0};
      tbl[4] = '{3'd4, 8'h09, 18'h0, 1'b0};
      tbl[5] = '{3'd5, 8'h00, 18'h0, 1'b0};
      tbl[6] = '{3'd7, 8'hFF, 18'h0, 1'b0};
      tbl[7] = '{3'd6, 8'h03, 18'h0A3D7, 1'b1};
      for (int i = 0; i < 8; i++) begin
         wr(tbl[i].addr, tbl[i].data);
         chk($sformatf("tbl%0d_acc", i), 64'(acc_inc), 64'(tbl[i].exp_acc));
         chk($sformatf("tbl%0d_tx_on", i), 64'(tx_on), 64'(tbl[i].exp_tx_on));
      end
      chk("cfg_coef", 64'(df_inc_coef), 5);
      chk("cfg_fact", 64'(df_inc_fact), 2);

      // RUN commit waits for the tick; period stays div+1
      repeat (12) cyc_step();
      wr(3'd0, 8'h00); wr(3'd1, 8'h10); wr(3'd2, 8'h00);
      wr(3'd6, 8'h03);
      wait_tick();
      chk("pend_acc_at_tick", 64'(acc_inc), 18'h0A3D7);
      cyc_step();
      chk("pend_acc_after", 64'(acc_inc), 18'h01000);
      n = 1;
      for (int i = 0; i < 64; i++) begin
         if (sample_tick) break;
         cyc_step();
         n++;
      end
      chk("tick_period", 64'(n), 10);

      // Audio delivery and underrun
      cyc_step();
      wr(3'd6, 8'h05);
      chk("ur_cleared", 64'(underrun), 0);
      push(8'h40);
      wait_tick(); cyc_step();
      chk("audio_40", 64'(audio), 8'h40);
      push(8'hC0);
      wait_tick(); cyc_step();
      chk("audio_c0", 64'(audio), 8'hC0);
      chk("ur_still_0", 64'(underrun), 0);
      wait_tick(); cyc_step();
      chk("audio_hold", 64'(audio), 8'hC0);
      chk("ur_set", 64'(underrun), 1);

      // Back-pressure: source holds valid while the buffer is full
      src_q = '{8'h11, 8'h22, 8'h33};
      stalled = 0;
      for (int i = 0; i < 80 && got_q.size() < 3; i++) begin
         audio_valid = (src_q.size() > 0);
         audio_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
         hs = audio_valid && audio_ready;
         if (audio_valid && !audio_ready) stalled = 1;
         tk = sample_tick;
         cyc_step();
         if (hs) void'(src_q.pop_front());
         if (tk) got_q.push_back(audio);
      end
      audio_valid = 0;
      chk("stall_seen", 64'(stalled), 1);
      chk("stall_cnt", 64'(got_q.size()), 3);
      for (int i = 0; i < got_q.size() && i < 3; i++)
         chk($sformatf("stall_s%0d", i), 64'(got_q[i]), 64'(8'h11 * (i + 1)));

      // Transmit disable, with or without the mute ramp
      push(8'h7F);
      wait_tick(); cyc_step();
      chk("mute_start", 64'(audio), 8'h7F);
      wr(3'd6, 8'h00);
`ifdef SOFT_MUTE_EN
      chk("mute_tx_on", 64'(tx_on), 1);
      for (int i = 6; i >= 0; i--) begin
         wait_tick(); cyc_step();
         chk($sformatf("mute_step%0d", i), 64'(audio), 64'((1 << i) - 1));
      end
      wait_tick(); cyc_step();
      chk("mute_done_tx_on", 64'(tx_on), 0);
`else
      chk("off_tx_on", 64'(tx_on), 0);
      chk("off_audio", 64'(audio), 0);
`endif

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         wr_en = ($urandom_range(0, 3) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom);
         if (wr_addr == 3'd4) wr_data = 8'($urandom_range(0, 5));
         if (wr_addr == 3'd5) wr_data = 8'h00;
         if (wr_addr == 3'd6) begin
            wr_data = {5'b0, 3'($urandom)};
            if ($urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
         end
         audio_valid = 1'($urandom);
         audio_in = 8'($urandom);
         cyc_step();
      end
      wr_en = 0; audio_valid = 0;

      // Asynchronous reset while transmitting
      wr(3'd6, 8'h01);
      chk("pre_reset_tx_on", 64'(tx_on), 1);
      #2 rst_n = 0;
      #1;
      chk("arst_acc", 64'(acc_inc), 0);
      chk("arst_audio", 64'(audio), 0);
      chk("arst_ready", 64'(audio_ready), 1);
      chk("arst_tx_on", 64'(tx_on), 0);
      chk("arst_tick", 64'(sample_tick), 0);
      chk("arst_ur", 64'(underrun), 0);
      #3 rst_n = 1;
      model_reset();
      repeat (20) cyc_step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
